// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder (two halfadder_g1 cells + OR) processes operands LSB-first, WIDTH cycles per op.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port that selects a_in - b_in (inverted b, carry-in 1).

module halfadder_g1 (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-2:0]   res_sh;
  logic [CNT_W-1:0]   count;
  logic               carry;

  logic               b_eff;
  logic               carry_init;
  logic               s1, c1, s_bit, c2, c_next;
  logic [WIDTH-1:0]   res_next;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  assign b_eff      = b_sh[0] ^ sub_q;
  assign carry_init = sub;
`else
  assign b_eff      = b_sh[0];
  assign carry_init = 1'b0;
`endif

  halfadder_g1 u_ha1 (.a(a_sh[0]), .b(b_eff), .s(s1),    .c(c1));
  halfadder_g1 u_ha2 (.a(s1),      .b(carry), .s(s_bit), .c(c2));
  assign c_next = c1 | c2;

  // New bit enters at the MSB; on the last edge this is the complete result.
  assign res_next = {s_bit, res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      count    <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            res_sh <= '0;
            count  <= '0;
            carry  <= carry_init;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SERIAL_ADD_SUB_EN
            sub_q  <= sub;
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next[WIDTH-1:1];
          carry  <= c_next;
          count  <= count + 1'b1;
          if (count == LAST) begin
            sum_out  <= res_next;
            cout_out <= c_next;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): vector table plus busy-start, reset-abort and held-start sequences.
// Sub vectors are included when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a_in(a_in),
    .b_in(b_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy),
    .done(done),
    .sum_out(sum_out),
    .cout_out(cout_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] es, input logic ec, input string tag);
    logic [W-1:0] prev;
    int           n;
    int           busy_n;
    logic         held;
    string        nm;
    nm = $sformatf("%s(sub=%0d)", tag, s);
    @(negedge clk);
    prev  = sum_out;
    a_in  = a;
    b_in  = b;
`ifdef SERIAL_ADD_SUB_EN
    sub   = s;
`endif
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    a_in   = ~a;
    b_in   = ~b;
    n      = 0;
    busy_n = 0;
    held   = 1'b1;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if (sum_out !== prev) held = 1'b0;
      @(negedge clk);
      n++;
    end
    if (busy) busy_n++;
    check({nm, " latency"}, n, W);
    check({nm, " sum"}, sum_out, es);
    check({nm, " cout"}, cout_out, ec);
    check({nm, " hold"}, held, 1'b1);
    check({nm, " busy_cycles"}, busy_n, W + 1);
    @(negedge clk);
    check({nm, " done_fall"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int dcount;
    int last;

    vecs.push_back('{a: 8'h00, b: 8'h00, s: 1'b0, sum: 8'h00, cout: 1'b0});
    vecs.push_back('{a: 8'hA5, b: 8'h5A, s: 1'b0, sum: 8'hFF, cout: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'h01, s: 1'b0, sum: 8'h00, cout: 1'b1});
    vecs.push_back('{a: 8'h80, b: 8'h80, s: 1'b0, sum: 8'h00, cout: 1'b1});
    vecs.push_back('{a: 8'hFF, b: 8'hFF, s: 1'b0, sum: 8'hFE, cout: 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{a: 8'h10, b: 8'h01, s: 1'b1, sum: 8'h0F, cout: 1'b1});
    vecs.push_back('{a: 8'h01, b: 8'h02, s: 1'b1, sum: 8'hFF, cout: 1'b0});
    vecs.push_back('{a: 8'h10, b: 8'h01, s: 1'b0, sum: 8'h11, cout: 1'b0});
`endif

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, cout_out, sum_out}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));

    // start requests during RUN and DONE must be ignored
    @(negedge clk);
    a_in  = 8'h12;
    b_in  = 8'h34;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dcount++;
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
      end else if (i == 3) begin
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_ignore done_count", dcount, 1);
    check("busy_ignore sum", sum_out, 8'h46);
    check("busy_ignore cout", cout_out, 1'b0);
    check("busy_ignore idle", busy, 1'b0);

    // reset in the middle of RUN aborts the operation
    a_in  = 8'h0F;
    b_in  = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort outputs", {busy, done, cout_out, sum_out}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dcount++;
      @(negedge clk);
    end
    check("abort no_activity", dcount, 0);
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "after_abort");

    // start held high: back-to-back operations every W+2 cycles
    @(negedge clk);
    a_in   = 8'h03;
    b_in   = 8'h04;
    start  = 1'b1;
    dcount = 0;
    last   = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        check($sformatf("held sum%0d", dcount), sum_out, 8'h07);
        if (last >= 0) check($sformatf("held interval%0d", dcount), i - last, W + 2);
        last = i;
      end
    end
    start = 1'b0;
    check("held done_count", dcount, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
